// File: rtl/mult_share_ctrl.sv
// Two-requester front end for a single shared 32x32 Wallace-tree multiplier.
// Round-robin grant, sign handled as magnitude multiply plus result negation, two registered stages.

module wallace32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic [63:0] cur [32];
    logic [63:0] nxt [32];
    logic [63:0] x, y, z;
    int          rows;

    // Carry-save reduction: each level turns groups of three rows into two
    // until two remain, then one carry-propagate add finishes the product.
    always_comb begin
        x    = '0;
        y    = '0;
        z    = '0;
        rows = 32;
        for (int i = 0; i < 32; i++) begin
            cur[i] = b[i] ? ({32'b0, a} << i) : 64'd0;
            nxt[i] = '0;
        end
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < 32; k++) begin
                nxt[k] = '0;
            end
            for (int t = 0; t < 10; t++) begin
                if (t < rows / 3) begin
                    x              = cur[3*t];
                    y              = cur[3*t+1];
                    z              = cur[3*t+2];
                    nxt[2*t]       = x ^ y ^ z;
                    nxt[2*t+1]     = ((x & y) | (x & z) | (y & z)) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < rows % 3) begin
                    nxt[(rows/3)*2 + r] = cur[(rows/3)*3 + r];
                end
            end
            for (int k = 0; k < 32; k++) begin
                cur[k] = nxt[k];
            end
            rows = (rows / 3) * 2 + rows % 3;
        end
        p = cur[0] + cur[1];
    end
endmodule

module mult_share_ctrl #(
    parameter int WIDTH   = 32,
    parameter bit RR_INIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req0_signed,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic               req1_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_id,
    output logic [2*WIDTH-1:0] out_prod
);
    logic               s1_valid_reg;
    logic [WIDTH-1:0]   s1_a_reg;
    logic [WIDTH-1:0]   s1_b_reg;
    logic               s1_neg_reg;
    logic               s1_id_reg;
    logic               out_valid_reg;
    logic               out_id_reg;
    logic [2*WIDTH-1:0] out_prod_reg;
    logic               last_grant_reg;

    logic               s2_free, s1_adv, s1_free;
    logic               grant, hs;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               sel_signed;
    logic [WIDTH-1:0]   mag_a_next, mag_b_next;
    logic               neg_next;
    logic [2*WIDTH-1:0] prod_raw, prod_next;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        s2_free    = !out_valid_reg || out_ready;
        s1_adv     = s1_valid_reg && s2_free;
        s1_free    = !s1_valid_reg || s1_adv;
        // With both valid the requester that did not win last time goes first.
        grant      = (req0_valid && req1_valid) ? !last_grant_reg : req1_valid;
        req0_ready = rst_n && s1_free && !grant && req0_valid;
        req1_ready = rst_n && s1_free && grant && req1_valid;
        hs         = req0_ready || req1_ready;
        sel_a      = grant ? req1_a : req0_a;
        sel_b      = grant ? req1_b : req0_b;
        sel_signed = grant ? req1_signed : req0_signed;
        mag_a_next = magnitude(sel_a, sel_signed);
        mag_b_next = magnitude(sel_b, sel_signed);
        neg_next   = sel_signed && (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
        // Negating a zero product yields zero, so no special case is needed.
        prod_next  = s1_neg_reg ? (~prod_raw + 1'b1) : prod_raw;
    end

    wallace32 u_wallace (
        .a (s1_a_reg),
        .b (s1_b_reg),
        .p (prod_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
            s1_neg_reg     <= 1'b0;
            s1_id_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_id_reg     <= 1'b0;
            out_prod_reg   <= '0;
            last_grant_reg <= RR_INIT;
        end else begin
            if (s1_free) begin
                s1_valid_reg <= hs;
                if (hs) begin
                    s1_a_reg   <= mag_a_next;
                    s1_b_reg   <= mag_b_next;
                    s1_neg_reg <= neg_next;
                    s1_id_reg  <= grant;
                end
            end
            if (s2_free) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_prod_reg <= prod_next;
                    out_id_reg   <= s1_id_reg;
                end
            end
            if (hs) begin
                last_grant_reg <= grant;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_id    = out_id_reg;
    assign out_prod  = out_prod_reg;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Randomized and directed bench for mult_share_ctrl against a transaction-level model
// that multiplies with native signed/unsigned 64-bit arithmetic.

module tb_mult_share_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, sg0, sg1, r0, r1, ordy;
    logic [31:0] a0, b0, a1, b1;
    logic        ov, oid;
    logic [63:0] oprod;

    always #5 clk = ~clk;

    mult_share_ctrl #(.WIDTH(32), .RR_INIT(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (v0),
        .req0_ready  (r0),
        .req0_a      (a0),
        .req0_b      (b0),
        .req0_signed (sg0),
        .req1_valid  (v1),
        .req1_ready  (r1),
        .req1_a      (a1),
        .req1_b      (b1),
        .req1_signed (sg1),
        .out_valid   (ov),
        .out_ready   (ordy),
        .out_id      (oid),
        .out_prod    (oprod)
    );

    typedef struct {
        logic        id;
        logic [63:0] prod;
        logic        has_gold;
        logic [63:0] gold;
    } op_t;

    int          checks = 0;
    int          errors = 0;
    logic        m_s1_v, m_s2_v, m_last;
    op_t         m_s1, m_s2;
    logic        dir_has;
    logic [63:0] dir_gold;
    logic        hs0, hs1;
    int          acc_ids[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic model_reset();
        m_s1_v = 1'b0;
        m_s2_v = 1'b0;
        m_last = 1'b1;
    endtask

    // One clock: inputs are already driven; check at the falling edge, then advance the model.
    task automatic step();
        logic s2f, s1f, g, e0, e1;
        op_t  n;
        @(negedge clk);
        check_eq("out_valid", 64'(ov), 64'(m_s2_v));
        if (m_s2_v) begin
            check_eq("out_id", 64'(oid), 64'(m_s2.id));
            check_eq("out_prod", oprod, m_s2.prod);
            if (m_s2.has_gold) check_eq("gold_prod", oprod, m_s2.gold);
        end
        s2f = !m_s2_v || ordy;
        s1f = !m_s1_v || s2f;
        g   = (v0 && v1) ? !m_last : v1;
        e0  = rst_n && s1f && v0 && !g;
        e1  = rst_n && s1f && v1 && g;
        check_eq("req0_ready", 64'(r0), 64'(e0));
        check_eq("req1_ready", 64'(r1), 64'(e1));
        if (ov && ordy && rst_n) $display("pop id=%0d prod=%h", oid, oprod);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (s2f) begin
                m_s2_v = m_s1_v;
                m_s2   = m_s1;
            end
            if (s1f) begin
                m_s1_v = e0 || e1;
                if (e0 || e1) begin
                    n.id       = g;
                    n.prod     = g ? ref_prod(a1, b1, sg1) : ref_prod(a0, b0, sg0);
                    n.has_gold = dir_has;
                    n.gold     = dir_gold;
                    m_s1       = n;
                    dir_has    = 1'b0;
                end
            end
            if (e0 || e1) begin
                m_last = g;
                acc_ids.push_back(int'(g));
            end
        end
        hs0 = e0;
        hs1 = e1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        v0   = 1'b0;
        v1   = 1'b0;
        ordy = rdy;
        repeat (n) step();
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] gold);
        v0 = !id; v1 = id; ordy = 1'b1;
        if (id) begin a1 = a; b1 = b; sg1 = sgn; end
        else    begin a0 = a; b0 = b; sg0 = sgn; end
        dir_has  = 1'b1;
        dir_gold = gold;
        step();
        check_eq("issue_accepted", 64'(id ? hs1 : hs0), 64'd1);
        v0 = 1'b0; v1 = 1'b0;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int base;
        logic p0, p1;
        v0 = 0; v1 = 0; sg0 = 0; sg1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        ordy = 1; dir_has = 0; dir_gold = 0; hs0 = 0; hs1 = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_out_prod", oprod, 64'd0);
        check_eq("rst_out_id", 64'(oid), 64'd0);
        idle(1, 1'b1);

        issue(1'b0, 32'h0001_869F, 32'h0000_0FFF, 1'b0, 64'd409495905);
        idle(3, 1'b1);
        issue(1'b1, 32'hFFFF_FD72, 32'd123, 1'b1, 64'hFFFF_FFFF_FFFE_C5C6);
        issue(1'b1, 32'hFFFF_FD72, 32'd123, 1'b0, 64'd528280896966);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        issue(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 64'h0);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        idle(3, 1'b1);

        // Back-pressure with both requesters waiting.
        v0 = 1; v1 = 1; a0 = 32'd7; b0 = 32'hFFFF_FFF0; sg0 = 1; a1 = 32'd12345; b1 = 32'd678; sg1 = 0;
        ordy = 1'b0;
        base = acc_ids.size();
        repeat (4) step();
        check_eq("bp_accepts", 64'(acc_ids.size() - base), 64'd2);
        idle(4, 1'b1);

        // Fill both stages, then reset in flight.
        v0 = 1; v1 = 0; a0 = 32'd3; b0 = 32'd5; sg0 = 0; ordy = 1'b0;
        repeat (3) step();
        v0 = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(1, 1'b1);

        // Contention right after reset: grants start at requester 0 and alternate.
        v0 = 1; v1 = 1; ordy = 1'b1; a0 = 32'hDEAD_BEEF; b0 = 32'd9; sg0 = 1; a1 = 32'd4; b1 = 32'hFFFF_FFFE; sg1 = 1;
        base = acc_ids.size();
        repeat (6) step();
        check_eq("cont_accepts", 64'(acc_ids.size() - base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < acc_ids.size()) check_eq("cont_grant", 64'(acc_ids[base + i]), 64'(i % 2));
        end
        idle(3, 1'b1);

        p0 = 0; p1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0) begin
                v0 = ($urandom_range(0, 2) != 0);
                a0 = rand_op(); b0 = rand_op(); sg0 = 1'($urandom_range(0, 1));
            end
            if (!p1) begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = rand_op(); b1 = rand_op(); sg1 = 1'($urandom_range(0, 1));
            end
            ordy = ($urandom_range(0, 3) != 0);
            step();
            p0 = v0 && !hs0;
            p1 = v1 && !hs1;
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
